// File: rtl/disp_pkg.sv
// Shared types and helpers for the display arbiter.
// Digit count, FSM states, anode lookup, leading-zero detect.
package disp_pkg;

  localparam int N_DIGIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OPEN
  } state_e;

  localparam logic [N_DIGIT-1:0][7:0] AN_LUT = {
    8'h7F, 8'hBF, 8'hDF, 8'hEF,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  // Index of the most significant nonzero nibble; 0 for a zero word.
  function automatic logic [2:0] msnz_idx(input logic [31:0] w);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < N_DIGIT; i++) begin
      if (w[4*i +: 4] != 4'h0) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_arb_rr_arb.sv
// Round-robin priority select.
// Searches req from ptr upward, wrapping modulo N.
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        vld_o = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % N);
      end
    end
    gnt_o = vld_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/disp_arb.sv
// Arbiter granting one requester the 8-digit display,
// with dwell-based round-robin and a multiplexed scan.
module disp_arb
  import disp_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int unsigned DWELL    = 50_000_000,
  parameter int unsigned SCAN_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic                 lz_en,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [3:0]           digit,
  output logic [7:0]           AN
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [31:0]      dwell_q, dwell_d;
  logic [15:0]      scan_q, scan_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [3:0]       digit_q, digit_d;

  logic [N_REQ-1:0] cand, win_oh;
  logic [PW-1:0]    win_idx, ptr_nx;
  logic             win_vld, owner_live, take, wrap, show;
  logic [2:0]       idx_nx;
  logic [31:0]      word;
  state_e           hold_st;

  assign cand       = req & ~grant_q;
  assign owner_live = |(req & grant_q);
  assign ptr_nx     = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign hold_st    = (DWELL == 1) ? OPEN : HOLD;

  rr_arb #(.N(N_REQ), .PW(PW)) u_rr (
    .req_i (cand),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: take = win_vld;
      HOLD, OPEN: begin
        if (!owner_live) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            dwell_d = '0;
          end
        end else if (state_q == HOLD) begin
          dwell_d = dwell_q + 32'd1;
          if (dwell_q + 32'd1 == DWELL - 32'd1) state_d = OPEN;
        end else begin
          take = win_vld;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      grant_d = win_oh;
      ptr_d   = ptr_nx;
      dwell_d = '0;
      state_d = hold_st;
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      word = word | ({32{grant_q[i]}} & req_data[32*i +: 32]);
    end
  end

  // Outputs are loaded for the index being advanced to.
  assign wrap    = (scan_q == 16'(SCAN_DIV - 1));
  assign scan_d  = wrap ? 16'd0 : scan_q + 16'd1;
  assign idx_nx  = idx_q + 3'd1;
  assign idx_d   = wrap ? idx_nx : idx_q;
  assign show    = busy && !(lz_en && (idx_nx > msnz_idx(word)));
  assign an_d    = !wrap ? an_q
                 : show  ? AN_LUT[idx_nx] : 8'hFF;
  assign digit_d = !wrap ? digit_q
                 : busy  ? word[{idx_nx, 2'b00} +: 4] : 4'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      dwell_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFF;
      digit_q <= 4'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign AN    = an_q;
  assign digit = digit_q;

endmodule

// File: tb/tb_disp_arb.sv
// Bench for disp_arb: grant sequencing checked directly,
// scan outputs checked against a queue of expected advances.
module tb_disp_arb;

  localparam int NR = 4;
  localparam int SD = 2;

  logic             clk;
  logic             rstn;
  logic [NR-1:0]    req;
  logic [32*NR-1:0] req_data;
  logic             lz_en;
  logic [NR-1:0]    grant;
  logic             busy;
  logic [3:0]       digit;
  logic [7:0]       AN;

  int n_cmp;
  int n_bad;
  int sc;
  int bidx;
  logic [11:0] sb[$];

  disp_arb #(.N_REQ(NR), .DWELL(4), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_data (req_data),
    .lz_en    (lz_en),
    .grant    (grant),
    .busy     (busy),
    .digit    (digit),
    .AN       (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] disp_exp(input int i,
                                           input logic [31:0] w,
                                           input logic lz,
                                           input logic own);
    int top;
    logic [7:0] an;
    logic [3:0] d;
    if (!own) return {8'hFF, 4'h0};
    top = 0;
    for (int k = 0; k < 8; k++)
      if (((w >> (4 * k)) & 32'hF) != 0) top = k;
    d  = 4'((w >> (4 * i)) & 32'hF);
    an = (lz && i > top) ? 8'hFF : ~(8'h01 << i);
    return {an, d};
  endfunction

  task automatic push_round(input logic [31:0] w,
                            input logic lz,
                            input logic own);
    for (int k = 1; k <= 8; k++)
      sb.push_back(disp_exp((bidx + k) % 8, w, lz, own));
  endtask

  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (!rstn) begin
      sc   = 0;
      bidx = 0;
    end else if (sc == SD - 1) begin
      sc   = 0;
      bidx = (bidx + 1) % 8;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("an", 32'(AN), 32'(e[11:4]));
        chk("digit", 32'(digit), 32'(e[3:0]));
      end
    end else begin
      sc++;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_an", 32'(AN), 32'hFF);
    chk("rst_digit", 32'(digit), 32'd0);
    step();
    rstn = 1'b1;
  endtask

  logic [3:0] exp_g2[12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                             4'b1000, 4'b1000, 4'b1000, 4'b1000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010};

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    sc       = 0;
    bidx     = 0;
    rstn     = 1'b0;
    req      = '0;
    req_data = '0;
    lz_en    = 1'b0;
    steps(2);
    chk("init_grant", 32'(grant), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_an", 32'(AN), 32'hFF);
    chk("init_digit", 32'(digit), 32'd0);
    rstn = 1'b1;

    push_round(32'h0, 1'b0, 1'b0);
    steps(16);

    req_data[31:0] = 32'h1234_5678;
    req            = 4'b0001;
    step();
    chk("g1", 32'(grant), 32'h1);
    chk("busy1", 32'(busy), 32'd1);
    push_round(32'h1234_5678, 1'b0, 1'b1);
    steps(15);

    req_data[31:0] = 32'h0000_00A0;
    lz_en          = 1'b1;
    push_round(32'h0000_00A0, 1'b1, 1'b1);
    steps(16);
    lz_en = 1'b0;
    push_round(32'h0000_00A0, 1'b0, 1'b1);
    steps(16);
    req_data[31:0] = 32'h0;
    lz_en          = 1'b1;
    push_round(32'h0, 1'b1, 1'b1);
    steps(16);
    lz_en = 1'b0;

    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("rr%0d", k), 32'(grant), 32'(exp_g2[k]));
    end

    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    step();
    chk("rel_a", 32'(grant), 32'h1);
    step();
    chk("rel_b", 32'(grant), 32'h1);
    req = 4'b0100;
    step();
    chk("rel_sw", 32'(grant), 32'h4);
    req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rel_hold%0d", k), 32'(grant), 32'h4);
    end
    step();
    chk("rel_next", 32'(grant), 32'h1);

    req = 4'b0000;
    do_reset();
    req_data[31:0]  = 32'h1234_5678;
    req_data[63:32] = 32'h9ABC_DEF0;
    req             = 4'b0011;
    step();
    chk("mid_g", 32'(grant), 32'h1);
    step();
    do_reset();
    sb.push_back(disp_exp(1, 32'h1234_5678, 1'b0, 1'b1));
    step();
    chk("regrant", 32'(grant), 32'h1);
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_arb.md
DISP_ARB -- requirements
Module: disp_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the 8-digit 7-segment display.
REQ-002 Parameter DWELL, default 50_000_000, minimum grant hold in clk cycles, range 1..2^32-1.
REQ-003 Parameter SCAN_DIV, default 10, clk cycles per digit scan step, range 1..2^16-1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  per-requester display request, level-sensitive.
REQ-007 req_data  input  32*N_REQ  requester i word at bits [32*i+31:32*i].
REQ-008 lz_en  input  1  leading-zero suppression enable.
REQ-009 grant  output  N_REQ  one-hot-or-zero owner indication, registered.
REQ-010 busy  output  1  high while any grant bit is set.
REQ-011 digit  output  4  hex nibble for the active digit, to the segment encoder.
REQ-012 AN  output  8  active-low digit enables, at most one bit low.

Function
REQ-013 FSM states: IDLE (no owner), HOLD (owner, dwell counter < DWELL-1), OPEN (owner, dwell expired).
REQ-014 IDLE: if any req, grant the round-robin winner next cycle, clear dwell counter, enter HOLD; else stay, grant=0.
REQ-015 Round-robin: search starts at index ptr, wraps modulo N_REQ; ptr becomes winner+1 (mod N_REQ) on each grant.
REQ-016 HOLD: dwell counter increments each cycle; on reaching DWELL-1 enter OPEN.
REQ-017 HOLD/OPEN: owner deasserting req releases the grant next cycle regardless of dwell; go to the next winner's HOLD if another req is pending, else IDLE.
REQ-018 OPEN: if any non-owner req is pending, switch grant to the round-robin winner next cycle and enter HOLD; else keep owner.
REQ-019 Grant switches are break-free: grant moves directly old->new in one cycle, never two bits set.
REQ-020 Scan counter counts 0..SCAN_DIV-1; at wrap, digit index idx advances 0->1->...->7->0.
REQ-021 On each index advance, AN and digit update in the same cycle: AN = ~(1<<idx), digit = owner word[4*idx+3:4*idx].
REQ-022 Owner data change or grant change takes effect at the next index advance; idx is never reset by a grant change.
REQ-023 IDLE: AN=8'hFF and digit=0 at every index advance; scanning counters keep running.
REQ-024 lz_en=1: digit positions above the most significant nonzero nibble drive AN bit high; digit 0 is always shown (word 0 shows a single "0").
REQ-025 lz_en change takes effect at the next index advance.

Reset
REQ-026 rstn low: state=IDLE, grant=0, busy=0, ptr=0, dwell counter=0, scan counter=0, idx=0, AN=8'hFF, digit=4'h0, all asynchronously.
REQ-027 First index advance after reset release occurs SCAN_DIV cycles later and selects idx=1; reset mid-grant drops the grant immediately with no pending-request memory.

Structure
REQ-028 Package disp_pkg holds N_DIGIT=8, the FSM state enum {IDLE, HOLD, OPEN}, and the active-low one-hot AN lookup constant.
REQ-029 Sub-module rr_arb (N_REQ-wide round-robin priority select from req and ptr, combinational) is instantiated once.
REQ-030 Leading-zero detection is a combinational function in disp_pkg; no other sub-modules.

Verification (bench params N_REQ=4, DWELL=4, SCAN_DIV=2)
REQ-031 Reset then req=4'b0001, req_data[31:0]=32'h1234_5678 -> grant=0001 one cycle after req; AN walks FD,FB,F7,...,FE every 2 cycles with digit 7,6,5,...,8 matching.
REQ-032 req=4'b1010 from IDLE with ptr=0 -> grant=0010, after 4 cycles grant=1000, after 4 more grant=0010; never two bits set.
REQ-033 Owner 0 granted, req drops to 0 on dwell cycle 1 with req[2]=1 -> grant=0100 next cycle, dwell counter restarts.
REQ-034 lz_en=1, owner word 32'h0000_00A0 -> AN low only for idx 0 and 1 (digits 0,A), AN=FF on idx 2..7; word 0 -> only idx 0 shown, digit 0.
REQ-035 rstn pulsed low mid-HOLD for one cycle -> grant=0, AN=FF, idx=0 asynchronously; with req still high, regrant one cycle after rstn rises, starting from ptr=0.
